byte_serial_tx: RTL and testbench
=================================

Name: byte_serial_tx

Overview:
- Serial transmit side for stored bytes: accepts one parallel byte through a load/ready handshake.
- Captures the byte into an internal holding register, then shifts it out on a single line as an asynchronous-serial frame: start bit, DATA_W data bits LSB first, one stop bit.
- Sits downstream of the byte storage registers and drives the board serial/LED line.
- The matching receiver reassembles the byte at the far end.

Parameters:
- DATA_W, 8, payload width in bits.
- CLKS_PER_BIT, 4, clock cycles each frame bit is held on tx; legal range >= 1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
- data  input  DATA_W  byte to transmit; sampled only on the accept edge.
- load  input  1  request to transmit data.
- ready  output  1  high when a load will be accepted.
- tx  output  1  serial line; idle high; registered output.
- busy  output  1  high while a frame is in progress.
- done  output  1  one-cycle pulse when a frame completes.

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-low on rst_n.
- Reset values: state=IDLE, tx=1, ready=1, busy=0, done=0, holding register=0, bit and cycle counters=0.
- Reset mid-frame: at the next rising edge with rst_n=0, the frame aborts. tx returns to 1 and all outputs take their reset values. No done pulse.
- States: IDLE, START, DATA, STOP.
- IDLE: tx=1, ready=1, busy=0.
  - Accept edge E0 = rising edge with ready=1 and load=1.
  - At E0, data is latched into the holding register and the state goes to START.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA: tx = holding[idx] for CLKS_PER_BIT cycles per bit, idx 0..DATA_W-1 (LSB first). After the last bit, go to STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Cycle timing after E0 (C = CLKS_PER_BIT, W = DATA_W):
  - Start bit occupies cycles [E0, E0+C).
  - Bit i occupies [E0+C(1+i), E0+C(2+i)).
  - Stop bit occupies [E0+C(W+1), E0+C(W+2)).
- Frame end:
  - At edge E0+C(W+2): state=IDLE, ready=1, busy=0.
  - done=1 for exactly the following cycle.
- Frame length is C(W+2) cycles. Earliest next accept edge is E0+C(W+2)+1, so minimum back-to-back spacing is C(W+2)+1 cycles. Stop-bit-to-next-start idle time is exactly 1 cycle.
- ready and busy are complementary at all times. Both are registered and change on the accept edge and the frame-end edge.
- load while busy=1 is ignored, with no queuing. Changes on data after E0 do not affect the frame in progress.
- load held high continuously: a new frame is accepted at every frame-end+1 edge.
- CLKS_PER_BIT=1: each bit is held one cycle; the frame is W+2 cycles long.
- Cycle counter width: ceil(log2(CLKS_PER_BIT)), minimum 1. The counter wraps to 0 on each bit boundary.
- Bit index width: ceil(log2(DATA_W)), minimum 1.
- No X on any output after reset.

Test Plan:
- Reset and idle: hold rst_n=0 for 3 cycles, then release with load=0 for 20 cycles -> tx=1, ready=1, busy=0, done=0 throughout.
- Single frame (defaults): load=1, data=8'hA5 for one cycle.
  - tx per 4-cycle slot is 0,1,0,1,0,0,1,0,1,1.
  - busy=1 for 40 cycles; done pulses once at cycle 40 after accept; ready=1 at the same edge.
- Load while busy: accept 8'h3C, then pulse load with data=8'hFF at cycle 12.
  - Frame still encodes 0,0,0,1,1,1,1,0,0,1.
  - Exactly one done pulse; 8'hFF is never sent.
- Back-to-back: hold load=1 with data 8'h01, then 8'h80.
  - Second start bit begins exactly 41 cycles after the first accept.
  - Two done pulses, 41 cycles apart.
- Reset mid-frame: accept 8'h00, assert rst_n=0 at cycle 17 for 1 cycle.
  - tx=1 and ready=1 from the next edge; no done pulse.
  - A new load of 8'h55 then transmits correctly.
- CLKS_PER_BIT=1: send 8'hC3 -> tx = 0,1,1,0,0,0,0,1,1,1 on consecutive cycles; done pulses 10 cycles after accept.

Source files
------------

// File: rtl/byte_serial_tx.sv
// byte_serial_tx: parallel-load asynchronous-serial transmitter.
// Frame is start bit, DATA_W data bits LSB first, one stop bit.
module byte_serial_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data,
  input  logic              load,
  output logic              ready,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int CW =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW =
    (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] CNT_LAST =
    CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST =
    IW'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;

  logic              bit_end;
  logic [CW-1:0]     cnt_inc;
  logic [IW-1:0]     idx_nxt;

  assign bit_end = (cnt_q == CNT_LAST);
  assign cnt_inc = bit_end ? '0 : cnt_q + 1'b1;
  assign idx_nxt = idx_q + 1'b1;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    ready_d = ready_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        tx_d  = 1'b1;
        if (load && ready_q) begin
          state_d = S_START;
          hold_d  = data;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          ready_d = 1'b0;
        end
      end
      S_START: begin
        cnt_d = cnt_inc;
        if (bit_end) begin
          state_d = S_DATA;
          idx_d   = '0;
          tx_d    = hold_q[0];
        end
      end
      S_DATA: begin
        cnt_d = cnt_inc;
        if (bit_end) begin
          if (idx_q == IDX_LAST) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            idx_d = idx_nxt;
            tx_d  = hold_q[idx_nxt];
          end
        end
      end
      S_STOP: begin
        cnt_d = cnt_inc;
        if (bit_end) begin
          state_d = S_IDLE;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
          ready_d = 1'b1;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      hold_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign tx    = tx_q;
  assign busy  = busy_q;
  assign ready = ready_q;
  assign done  = done_q;

endmodule

// File: tb/tb_byte_serial_tx.sv
// tb_byte_serial_tx: scoreboard bench for byte_serial_tx.
// Instance a uses 4 clocks/bit, instance b uses 1 clock/bit.
module tb_byte_serial_tx;

  localparam int W  = 8;
  localparam int CA = 4;
  localparam int CB = 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         rst_smp;
  logic [W-1:0] data_a = '0;
  logic [W-1:0] data_b = '0;
  logic         load_a = 1'b0;
  logic         load_b = 1'b0;
  logic         ready_a, tx_a, busy_a, done_a;
  logic         ready_b, tx_b, busy_b, done_b;

  always #5 clk = ~clk;
  always @(posedge clk) rst_smp <= rst_n;

  byte_serial_tx #(.DATA_W(W), .CLKS_PER_BIT(CA)) u_a (
    .clk  (clk),
    .rst_n(rst_n),
    .data (data_a),
    .load (load_a),
    .ready(ready_a),
    .tx   (tx_a),
    .busy (busy_a),
    .done (done_a)
  );

  byte_serial_tx #(.DATA_W(W), .CLKS_PER_BIT(CB)) u_b (
    .clk  (clk),
    .rst_n(rst_n),
    .data (data_b),
    .load (load_b),
    .ready(ready_b),
    .tx   (tx_b),
    .busy (busy_b),
    .done (done_b)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  logic [W-1:0] sb_a[$];
  logic [W-1:0] sb_b[$];

  logic [1:0] tx_v, busy_v, ready_v, done_v;
  assign tx_v    = {tx_b, tx_a};
  assign busy_v  = {busy_b, busy_a};
  assign ready_v = {ready_b, ready_a};
  assign done_v  = {done_b, done_a};

  string        nm[2] = '{"a", "b"};
  int           pos[2] = '{-1, -1};
  logic [W-1:0] cur[2];
  int           n_start[2] = '{0, 0};
  int           n_done[2] = '{0, 0};
  int           t_start[2], t_start_prev[2];
  int           t_done[2], t_done_prev[2];
  int           cyc = 0;

  // Frame monitor: pops the expected byte at the start bit
  // and checks every cycle of the frame plus the done cycle.
  always @(negedge clk) begin
    int   c, k;
    logic eb;
    cyc++;
    for (int d = 0; d < 2; d++) begin
      c = (d == 0) ? CA : CB;
      if (rst_smp !== 1'b1) begin
        pos[d] = -1;
        chk({nm[d], "_rst_tx"},    32'(tx_v[d]),    1);
        chk({nm[d], "_rst_ready"}, 32'(ready_v[d]), 1);
        chk({nm[d], "_rst_busy"},  32'(busy_v[d]),  0);
        chk({nm[d], "_rst_done"},  32'(done_v[d]),  0);
      end else if (pos[d] < 0) begin
        if (busy_v[d] === 1'b1 || tx_v[d] !== 1'b1) begin
          n_start[d]++;
          t_start_prev[d] = t_start[d];
          t_start[d] = cyc;
          if (d == 0) begin
            chk("a_frame_expected", 32'(sb_a.size() != 0), 1);
            if (sb_a.size() != 0) cur[d] = sb_a.pop_front();
          end else begin
            chk("b_frame_expected", 32'(sb_b.size() != 0), 1);
            if (sb_b.size() != 0) cur[d] = sb_b.pop_front();
          end
          pos[d] = 0;
        end else begin
          chk({nm[d], "_idle_ready"}, 32'(ready_v[d]), 1);
          chk({nm[d], "_idle_busy"},  32'(busy_v[d]),  0);
          chk({nm[d], "_idle_done"},  32'(done_v[d]),  0);
        end
      end
      if (rst_smp === 1'b1 && pos[d] >= 0) begin
        if (pos[d] == c * (W + 2)) begin
          chk({nm[d], "_end_done"},  32'(done_v[d]),  1);
          chk({nm[d], "_end_ready"}, 32'(ready_v[d]), 1);
          chk({nm[d], "_end_busy"},  32'(busy_v[d]),  0);
          chk({nm[d], "_end_tx"},    32'(tx_v[d]),    1);
          n_done[d]++;
          t_done_prev[d] = t_done[d];
          t_done[d] = cyc;
          pos[d] = -1;
        end else begin
          k = pos[d] / c;
          if (k == 0)      eb = 1'b0;
          else if (k <= W) eb = cur[d][k-1];
          else             eb = 1'b1;
          chk({nm[d], "_frame_tx"},    32'(tx_v[d]),    32'(eb));
          chk({nm[d], "_frame_busy"},  32'(busy_v[d]),  1);
          chk({nm[d], "_frame_ready"}, 32'(ready_v[d]), 0);
          chk({nm[d], "_frame_done"},  32'(done_v[d]),  0);
          pos[d]++;
        end
      end
    end
  end

  task automatic send(input int d, input logic [W-1:0] v);
    @(posedge clk); #1;
    if (d == 0) begin
      load_a = 1'b1; data_a = v; sb_a.push_back(v);
    end else begin
      load_b = 1'b1; data_b = v; sb_b.push_back(v);
    end
    @(posedge clk); #1;
    load_a = 1'b0;
    load_b = 1'b0;
    if (d == 0) data_a = ~v;
    else        data_b = ~v;
  endtask

  task automatic wait_cnt(input int d, input bit is_done,
                          input int tgt, input int lim);
    int n = 0;
    while ((is_done ? n_done[d] : n_start[d]) < tgt
           && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk(is_done ? "wait_done" : "wait_start",
        32'((is_done ? n_done[d] : n_start[d]) >= tgt), 1);
  endtask

  initial begin
    int nd, ns;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(posedge clk);

    send(0, 8'hA5);
    wait_cnt(0, 1'b1, 1, 60);
    chk("a5_done_latency", t_done[0] - t_start[0], 40);

    repeat (3) @(posedge clk);
    nd = n_done[0];
    send(0, 8'h3C);
    repeat (11) @(posedge clk);
    #1 load_a = 1'b1; data_a = 8'hFF;
    @(posedge clk);
    #1 load_a = 1'b0;
    wait_cnt(0, 1'b1, nd + 1, 60);
    repeat (50) @(posedge clk);
    chk("busy_load_one_done", n_done[0], nd + 1);

    nd = n_done[0];
    ns = n_start[0];
    @(posedge clk);
    #1 load_a = 1'b1; data_a = 8'h01; sb_a.push_back(8'h01);
    @(posedge clk);
    #1 data_a = 8'h80; sb_a.push_back(8'h80);
    wait_cnt(0, 1'b0, ns + 2, 80);
    @(posedge clk);
    #1 load_a = 1'b0;
    wait_cnt(0, 1'b1, nd + 2, 100);
    chk("b2b_start_gap", t_start[0] - t_start_prev[0], 41);
    chk("b2b_done_gap",  t_done[0] - t_done_prev[0],   41);

    repeat (3) @(posedge clk);
    nd = n_done[0];
    send(0, 8'h00);
    repeat (15) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (60) @(posedge clk);
    chk("midrst_no_done", n_done[0], nd);
    send(0, 8'h55);
    wait_cnt(0, 1'b1, nd + 1, 60);
    chk("after_rst_done_latency", t_done[0] - t_start[0], 40);

    repeat (3) @(posedge clk);
    send(1, 8'hC3);
    wait_cnt(1, 1'b1, 1, 30);
    chk("c3_done_latency", t_done[1] - t_start[1], 10);

    repeat (5) @(posedge clk);
    chk("sb_a_empty", sb_a.size(), 0);
    chk("sb_b_empty", sb_b.size(), 0);
    chk("a_frames", n_done[0], 5);
    chk("b_frames", n_done[1], 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
